spi_master: RTL and testbench

8-bit SPI bus master (mode 0: SCK idles low, data sampled on SCK rising edge, changed on falling edge, MSB first, SSEL active low) for talking to the team's oversampling SPI slave blocks from the same FPGA. Converts a parallel byte handshake into SCK/MOSI/SSEL waveforms and captures MISO into a received byte. Supports multi-byte bursts by keeping SSEL low between bytes until a byte flagged as last completes.

---
 rtl/spi_master_if.sv | 12 +
 rtl/spi_master.sv | 170 +++++++++++++++++
 tb/tb_spi_master.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - parallel byte handshake between a requester and spi_master
interface spi_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  modport master (output start, tx_data, tx_last, input busy, done, rx_data);
  modport slave  (input start, tx_data, tx_last, output busy, done, rx_data);
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode 0 SPI byte master with SSEL held across bursts
// Optional: SPI_MASTER_LOOPBACK_EN feeds the registered MOSI back into the rx shifter.
module spi_master #(
  parameter int CLK_DIV = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  bus,
  output logic         SCK,
  output logic         MOSI,
  input  logic         MISO,
  output logic         SSEL
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;
  localparam logic [2:0] S_GAP      = 3'd6;
  localparam logic [7:0] PHASE_MAX  = 8'(CLK_DIV - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       last_q, last_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       ssel_q, ssel_d;
  logic       done_q, done_d;
  logic       miso_s1_q, miso_s2_q;
  logic       rx_bit;
  logic       accept;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = mosi_q;
`else
  assign rx_bit = miso_s2_q;
`endif

  // A start coinciding with done belongs to the byte still finishing, so it is dropped.
  assign accept = bus.start && (state_q == S_IDLE || state_q == S_WAIT) && !done_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    last_d    = last_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ssel_d    = ssel_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (accept) begin
          tx_sr_d = bus.tx_data;
          last_d  = bus.tx_last;
          ssel_d  = 1'b0;
          mosi_d  = bus.tx_data[7];
          phase_d = PHASE_MAX;
          bit_d   = 3'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_q == 8'd0) begin
          state_d = S_SHIFT_HI;
          sck_d   = 1'b1;
          phase_d = PHASE_MAX;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      S_SHIFT_HI: begin
        if (phase_q == PHASE_MAX) rx_sr_d = {rx_sr_q[6:0], rx_bit};
        if (phase_q == 8'd0) begin
          state_d = S_SHIFT_LO;
          sck_d   = 1'b0;
          phase_d = PHASE_MAX;
          if (bit_q != 3'd7) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            mosi_d  = tx_sr_q[6];
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      S_SHIFT_LO: begin
        if (phase_q == 8'd0) begin
          phase_d = PHASE_MAX;
          if (bit_q == 3'd7) begin
            state_d = S_HOLD;
            bit_d   = 3'd0;
          end else begin
            state_d = S_SHIFT_HI;
            sck_d   = 1'b1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (phase_q == 8'd0) begin
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          phase_d   = PHASE_MAX;
          if (last_q) begin
            ssel_d  = 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      S_GAP: begin
        if (phase_q == 8'd0) state_d = S_IDLE;
        else                 phase_d = phase_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= 8'd0;
      bit_q     <= 3'd0;
      tx_sr_q   <= 8'd0;
      rx_sr_q   <= 8'd0;
      rx_data_q <= 8'd0;
      last_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ssel_q    <= 1'b1;
      done_q    <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      last_q    <= last_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ssel_q    <= ssel_d;
      done_q    <= done_d;
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign SCK         = sck_q;
  assign MOSI        = mosi_q;
  assign SSEL        = ssel_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = !(state_q == S_IDLE || state_q == S_WAIT);
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master with a mode 0 slave model
module tb_spi_master;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck, mosi, miso, ssel;
  spi_master_if bus_if ();

  spi_master #(.CLK_DIV(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if),
    .SCK  (sck),
    .MOSI (mosi),
    .MISO (miso),
    .SSEL (ssel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave: presents the MSB while selected and advances one bit on every SCK falling edge.
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] s_cnt = 3'd0;
  logic       s_prev_sck = 1'b0;
  logic       miso_force = 1'b0;
  logic [2:0] s_idx;
  assign s_idx = 3'd7 - s_cnt;
  assign miso  = miso_force ? 1'b1 : slave_byte[s_idx];

  always @(negedge clk) begin
    if (ssel) s_cnt <= 3'd0;
    else if (s_prev_sck && !sck) s_cnt <= s_cnt + 3'd1;
    s_prev_sck <= sck;
  end

  task automatic xfer(input logic [7:0] b, input logic last, input logic [7:0] sb, input int poke_n,
                      output int done_n, output logic [7:0] rx, output int rises, output int first_rise,
                      output logic [7:0] mcap, output logic ssel_early, output logic ssel_at_done,
                      output logic cyc1_ok);
    logic p_sck;
    slave_byte = sb;
    done_n = -1; rx = 8'h00; rises = 0; first_rise = -1; mcap = 8'h00;
    ssel_early = 1'b0; ssel_at_done = 1'b0; cyc1_ok = 1'b0; p_sck = 1'b0;
    bus_if.start = 1'b1; bus_if.tx_data = b; bus_if.tx_last = last;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int n = 1; n <= 30 * D; n++) begin
      if (n == 1) cyc1_ok = (bus_if.busy === 1'b1 && ssel === 1'b0);
      if (n == poke_n) begin
        bus_if.start = 1'b1; bus_if.tx_data = 8'h0F; bus_if.tx_last = ~last;
      end
      if (n == poke_n + 1) bus_if.start = 1'b0;
      if (!p_sck && sck) begin
        rises++;
        if (first_rise < 0) first_rise = n;
        mcap = {mcap[6:0], mosi};
      end
      p_sck = sck;
      if (bus_if.done === 1'b1) begin
        done_n = n; rx = bus_if.rx_data; ssel_at_done = ssel;
        break;
      end
      if (ssel !== 1'b0) ssel_early = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus_if.busy !== 1'b0 && cycles < 40 * D) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  int done_n, rises, first_rise, wcyc;
  logic [7:0] rx, mcap;
  logic ssel_early, ssel_at_done, cyc1_ok;

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ssel !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || bus_if.busy !== 1'b0 ||
          bus_if.done !== 1'b0 || bus_if.rx_data !== 8'h00) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL reset_idle: %0d bad cycles, want 0", bad); end
    n_cmp++; if (ssel !== 1'b1) begin n_bad++; $display("FAIL reset_ssel: got %b want 1", ssel); end
    n_cmp++; if (bus_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h want 00", bus_if.rx_data); end
  endtask

  task automatic test_single();
    int n;
    xfer(8'hA5, 1'b1, 8'h3C, 0, done_n, rx, rises, first_rise, mcap, ssel_early, ssel_at_done, cyc1_ok);
    n_cmp++; if (cyc1_ok !== 1'b1) begin n_bad++; $display("FAIL single_cycle1: busy/ssel got %b want busy=1 ssel=0", cyc1_ok); end
    n_cmp++; if (first_rise !== D + 1) begin n_bad++; $display("FAIL single_first_rise: got %0d want %0d", first_rise, D + 1); end
    n_cmp++; if (rises !== 8) begin n_bad++; $display("FAIL single_rises: got %0d want 8", rises); end
    n_cmp++; if (mcap !== 8'hA5) begin n_bad++; $display("FAIL single_mosi: got %h want a5", mcap); end
    n_cmp++; if (done_n !== 145) begin n_bad++; $display("FAIL single_done_cycle: got %0d want 145", done_n); end
    n_cmp++; if (rx !== 8'h3C) begin n_bad++; $display("FAIL single_rx: got %h want 3c", rx); end
    n_cmp++; if (ssel_at_done !== 1'b1 || ssel_early !== 1'b0) begin
      n_bad++; $display("FAIL single_ssel: at_done=%b early_high=%b want 1/0", ssel_at_done, ssel_early);
    end
    n = done_n;
    while (bus_if.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== 153) begin n_bad++; $display("FAIL single_busy_fall: got %0d want 153", n); end
  endtask

  task automatic test_burst();
    xfer(8'h11, 1'b0, 8'h05, 0, done_n, rx, rises, first_rise, mcap, ssel_early, ssel_at_done, cyc1_ok);
    n_cmp++; if (rx !== 8'h05 || done_n !== 145) begin n_bad++; $display("FAIL burst_b0: rx=%h cyc=%0d want 05/145", rx, done_n); end
    n_cmp++; if (ssel_at_done !== 1'b0 || ssel_early !== 1'b0) begin n_bad++; $display("FAIL burst_b0_ssel: at_done=%b early=%b want 0/0", ssel_at_done, ssel_early); end
    @(negedge clk);
    n_cmp++; if (bus_if.busy !== 1'b0 || ssel !== 1'b0) begin n_bad++; $display("FAIL burst_wait: busy=%b ssel=%b want 0/0", bus_if.busy, ssel); end
    xfer(8'h22, 1'b0, 8'h00, 0, done_n, rx, rises, first_rise, mcap, ssel_early, ssel_at_done, cyc1_ok);
    n_cmp++; if (rx !== 8'h00 || ssel_at_done !== 1'b0 || ssel_early !== 1'b0 || mcap !== 8'h22) begin
      n_bad++; $display("FAIL burst_b1: rx=%h ssel=%b early=%b mosi=%h want 00/0/0/22", rx, ssel_at_done, ssel_early, mcap);
    end
    @(negedge clk);
    xfer(8'h33, 1'b1, 8'h00, 0, done_n, rx, rises, first_rise, mcap, ssel_early, ssel_at_done, cyc1_ok);
    n_cmp++; if (rx !== 8'h00 || done_n !== 145 || mcap !== 8'h33) begin
      n_bad++; $display("FAIL burst_b2: rx=%h cyc=%0d mosi=%h want 00/145/33", rx, done_n, mcap);
    end
    n_cmp++; if (ssel_at_done !== 1'b1 || ssel_early !== 1'b0) begin n_bad++; $display("FAIL burst_b2_ssel: at_done=%b early=%b want 1/0", ssel_at_done, ssel_early); end
    wait_idle(wcyc);
  endtask

  task automatic test_ignored_start();
    int extra;
    xfer(8'hF0, 1'b1, 8'h99, D + 3, done_n, rx, rises, first_rise, mcap, ssel_early, ssel_at_done, cyc1_ok);
    n_cmp++; if (mcap !== 8'hF0 || rx !== 8'h99 || done_n !== 145) begin
      n_bad++; $display("FAIL ignore_xfer: mosi=%h rx=%h cyc=%0d want f0/99/145", mcap, rx, done_n);
    end
    n_cmp++; if (ssel_at_done !== 1'b1) begin n_bad++; $display("FAIL ignore_last: ssel=%b want 1", ssel_at_done); end
    extra = 0;
    for (int i = 0; i < 30 * D; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0 || bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_extra: dones=%0d busy=%b want 0/0", extra, bus_if.busy); end
  endtask

  task automatic test_reset_mid();
    int dones;
    slave_byte = 8'h00;
    bus_if.start = 1'b1; bus_if.tx_data = 8'h3C; bus_if.tx_last = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (74) @(negedge clk);
    n_cmp++; if (sck !== 1'b1 || mosi !== 1'b1) begin n_bad++; $display("FAIL mid_bit4: sck=%b mosi=%b want 1/1", sck, mosi); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ssel !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || bus_if.busy !== 1'b0 ||
                 bus_if.done !== 1'b0 || bus_if.rx_data !== 8'h00) begin
      n_bad++; $display("FAIL mid_async: ssel=%b sck=%b mosi=%b busy=%b done=%b rx=%h want 1/0/0/0/0/00",
                        ssel, sck, mosi, bus_if.busy, bus_if.done, bus_if.rx_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30 * D; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", dones); end
    xfer(8'h81, 1'b1, 8'h7E, 0, done_n, rx, rises, first_rise, mcap, ssel_early, ssel_at_done, cyc1_ok);
    n_cmp++; if (mcap !== 8'h81 || rx !== 8'h7E || done_n !== 145) begin
      n_bad++; $display("FAIL mid_recover: mosi=%h rx=%h cyc=%0d want 81/7e/145", mcap, rx, done_n);
    end
    wait_idle(wcyc);
  endtask

  task automatic test_loopback();
    logic [7:0] want;
`ifdef SPI_MASTER_LOOPBACK_EN
    want = 8'h5A;
`else
    want = 8'hFF;
`endif
    miso_force = 1'b1;
    xfer(8'h5A, 1'b1, 8'h00, 0, done_n, rx, rises, first_rise, mcap, ssel_early, ssel_at_done, cyc1_ok);
    n_cmp++; if (rx !== want) begin n_bad++; $display("FAIL loopback_rx: got %h want %h", rx, want); end
    miso_force = 1'b0;
    wait_idle(wcyc);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.tx_data = 8'h00;
    bus_if.tx_last = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_ignored_start();
    test_reset_mid();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
